// File: rtl/pipe_share_pkg.sv
// Shared types and helpers for the pipe_share_arbiter block.
// Contents: requester-ID width function, tag slot struct, statistics counter width.
// Optional build macro used by the top: PIPE_SHARE_STATS_EN (statistics counters).
package pipe_share_pkg;

  // Largest supported requester count is 16, so a 4-bit tag covers every build.
  localparam int MAX_ID_W = 4;
  localparam int STAT_W   = 32;

  // Requester tag width; a single-bit tag is kept even for degenerate counts.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // One slot of the latency-matched tag shift register.
  typedef struct packed {
    logic                vld;
    logic [MAX_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first eligible requester at or after ptr.
// Ports: eligible (per-requester), ptr (search start) -> grant (one-hot), idx, any.
// Zero latency; pointer state is owned by the caller.
module rr_arbiter
  import pipe_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eligible,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  // One extra bit so ptr+k can be folded back below NUM_REQ for non-power-of-2 counts.
  logic [ID_W:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ)) cand = cand - (ID_W+1)'(NUM_REQ);
      if (!any && eligible[cand[ID_W-1:0]]) begin
        any = 1'b1;
        idx = cand[ID_W-1:0];
      end
    end
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/pipe_share_arbiter.sv
// Shares one fixed-latency increment pipeline among NUM_REQ requesters (round-robin, 1 op/cycle).
// Ports: req_* (operands in), pipe_* (pipeline side), rsp_* (one-entry result buffers),
//   err_orphan (sticky tag/result mismatch), stat_issued/stat_wait (zero unless PIPE_SHARE_STATS_EN).
// Grant at T gives rsp_valid at T+PIPE_LAT+1; a requester is not re-granted until its buffer drains.
module pipe_share_arbiter
  import pipe_share_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int PIPE_LAT = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       pipe_input_valid,
  output logic [DATA_W-1:0]          pipe_x,
  input  logic                       pipe_output_valid,
  input  logic [DATA_W-1:0]          pipe_out,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0]  rsp_data,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic                       err_orphan,
  output logic [STAT_W-1:0]          stat_issued,
  output logic [STAT_W-1:0]          stat_wait
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0] busy;
  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  tag_t               tag_q [PIPE_LAT];
  tag_t               tail;
  logic               result_wr;

  // busy is registered, so a buffer popped this cycle is only re-eligible next cycle.
  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .eligible (req_valid & ~busy),
    .ptr      (ptr),
    .grant    (grant),
    .idx      (gnt_idx),
    .any      (gnt_any)
  );

  assign req_ready        = grant;
  assign pipe_input_valid = gnt_any;

  always_comb begin
    pipe_x = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) pipe_x = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Tail of the tag pipe lines up with the pipeline's output strobe.
  assign tail      = tag_q[PIPE_LAT-1];
  assign result_wr = pipe_output_valid & tail.vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < PIPE_LAT; s++) tag_q[s] <= '0;
    end else begin
      tag_q[0] <= '{vld: gnt_any, id: MAX_ID_W'(gnt_idx)};
      for (int s = 1; s < PIPE_LAT; s++) tag_q[s] <= tag_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      ptr        <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      err_orphan <= 1'b0;
    end else begin
      busy <= (busy | grant) & ~(rsp_valid & rsp_ready);
      if (gnt_any) begin
        ptr <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      end
      // A write and a pop to the same buffer never coincide: busy holds off reissue.
      for (int i = 0; i < NUM_REQ; i++) begin
        if (result_wr && tail.id == MAX_ID_W'(i)) begin
          rsp_valid[i]                   <= 1'b1;
          rsp_data[i*DATA_W +: DATA_W]   <= pipe_out;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i] <= 1'b0;
        end
      end
      // Result without a tag, or tag without a result: both mean lost bookkeeping.
      if (pipe_output_valid != tail.vld) err_orphan <= 1'b1;
    end
  end

`ifdef PIPE_SHARE_STATS_EN
  logic [STAT_W-1:0] issued_q;
  logic [STAT_W-1:0] wait_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      wait_q   <= '0;
    end else begin
      if (gnt_any) issued_q <= issued_q + STAT_W'(1);
      if (|(req_valid & ~grant)) wait_q <= wait_q + STAT_W'(1);
    end
  end

  assign stat_issued = issued_q;
  assign stat_wait   = wait_q;
`else
  assign stat_issued = '0;
  assign stat_wait   = '0;
`endif

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Directed bench for pipe_share_arbiter with NUM_REQ=4, DATA_W=32, PIPE_LAT=2.
// Holds a two-stage increment pipeline model on the pipe_* side; expected values are hand-computed.
// Inputs driven and outputs sampled at the falling clock edge.
module tb_pipe_share_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            pipe_input_valid;
  logic [DW-1:0]   pipe_x;
  logic            pipe_output_valid;
  logic [DW-1:0]   pipe_out;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic [N-1:0]    rsp_ready;
  logic            err_orphan;
  logic [31:0]     stat_issued;
  logic [31:0]     stat_wait;

  logic            force_ov;
  logic            pv1, pv2;
  logic [DW-1:0]   px1, px2;

  int nvec = 0;
  int nerr = 0;
  int gcount;

  pipe_share_arbiter #(.NUM_REQ(N), .DATA_W(DW), .PIPE_LAT(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_data          (req_data),
    .req_ready         (req_ready),
    .pipe_input_valid  (pipe_input_valid),
    .pipe_x            (pipe_x),
    .pipe_output_valid (pipe_output_valid),
    .pipe_out          (pipe_out),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .rsp_ready         (rsp_ready),
    .err_orphan        (err_orphan),
    .stat_issued       (stat_issued),
    .stat_wait         (stat_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-cycle increment pipeline, reset together with the arbiter.
  always @(posedge clk) begin
    if (rst) begin
      pv1 <= 1'b0; pv2 <= 1'b0; px1 <= '0; px2 <= '0;
    end else begin
      pv1 <= pipe_input_valid; px1 <= pipe_x + 32'd1;
      pv2 <= pv1;              px2 <= px1;
    end
  end
  assign pipe_output_valid = pv2 | force_ov;
  assign pipe_out          = px2;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = '0; force_ov = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data0", 64'(rsp_data[0 +: DW]), 64'h0);
    chk("rst_err", 64'(err_orphan), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_piv", 64'(pipe_input_valid), 64'h0);

    // Single op on requester 0: issue at T, result visible at T+3
    req_valid = 4'b0001; req_data[0 +: DW] = 32'h0000_0005;
    #1;
    chk("t1_grant", 64'(req_ready), 64'h1);
    chk("t1_piv", 64'(pipe_input_valid), 64'h1);
    chk("t1_pipe_x", 64'(pipe_x), 64'h5);
    tick();
    chk("t1_busy_blocks", 64'(req_ready), 64'h0);
    chk("t1_rsp_T1", 64'(rsp_valid), 64'h0);
    tick();
    chk("t1_rsp_T2", 64'(rsp_valid), 64'h0);
    tick();
    chk("t1_rsp_T3", 64'(rsp_valid), 64'h1);
    chk("t1_data", 64'(rsp_data[0 +: DW]), 64'h6);
    req_valid = '0; rsp_ready = 4'b0001;
    tick();
    chk("t1_pop", 64'(rsp_valid), 64'h0);

    // All four at once: grants 0..3 on consecutive cycles, results 3 cycles later
    rst = 1'b1; tick(); rst = 1'b0;
    rsp_ready = 4'b1111; req_valid = 4'b1111;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 32'h10 * (i + 1);
    for (int k = 0; k < 7; k++) begin
      if (k == 4) req_valid = '0;
      #1;
      if (k < 4) begin
        chk($sformatf("t2_grant_%0d", k), 64'(req_ready), 64'(4'b0001 << k));
        chk($sformatf("t2_pipe_x_%0d", k), 64'(pipe_x), 64'(32'h10 * (k + 1)));
      end
      if (k >= 3) begin
        chk($sformatf("t2_rsp_valid_%0d", k - 3), 64'(rsp_valid), 64'(4'b0001 << (k - 3)));
        chk($sformatf("t2_rsp_data_%0d", k - 3), 64'(rsp_data[(k-3)*DW +: DW]),
            64'(32'h10 * (k - 2) + 1));
      end
      tick();
    end
    chk("t2_drained", 64'(rsp_valid), 64'h0);

    // Requester 2 held off by rsp_ready: exactly one grant, data held stable
    rsp_ready = 4'b1011; req_valid = 4'b0100; req_data[2*DW +: DW] = 32'h77;
    gcount = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req_ready[2]) gcount++;
      if (c >= 3) begin
        chk($sformatf("t3_hold_valid_%0d", c), 64'(rsp_valid), 64'h4);
        chk($sformatf("t3_hold_data_%0d", c), 64'(rsp_data[2*DW +: DW]), 64'h78);
      end
      tick();
    end
    chk("t3_grant_count", 64'(gcount), 64'h1);
    req_valid = '0; rsp_ready = 4'b1111;
    tick();
    chk("t3_pop", 64'(rsp_valid), 64'h0);

    // All-ones operand wraps to zero
    req_valid = 4'b0001; req_data[0 +: DW] = 32'hFFFF_FFFF;
    #1;
    chk("t4_pipe_x", 64'(pipe_x), 64'hFFFF_FFFF);
    tick();
    req_valid = '0;
    tick(); tick();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t4_rsp_data", 64'(rsp_data[0 +: DW]), 64'h0);
    tick();
`ifndef PIPE_SHARE_STATS_EN
    chk("t4_stat_issued_off", 64'(stat_issued), 64'h0);
    chk("t4_stat_wait_off", 64'(stat_wait), 64'h0);
`endif

    // Result strobe with nothing in flight
    tick();
    chk("t5_err_before", 64'(err_orphan), 64'h0);
    force_ov = 1'b1;
    tick();
    force_ov = 1'b0;
    chk("t5_err_set", 64'(err_orphan), 64'h1);
    chk("t5_no_rsp", 64'(rsp_valid), 64'h0);
    tick();
    chk("t5_err_sticky", 64'(err_orphan), 64'h1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t5_err_cleared", 64'(err_orphan), 64'h0);

    // Reset one cycle after a grant discards the in-flight op
    req_valid = 4'b0010; req_data[1*DW +: DW] = 32'h55;
    #1;
    chk("t6_grant", 64'(req_ready), 64'h2);
    tick();
    rst = 1'b1; req_valid = '0;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t6_no_rsp_%0d", c), 64'(rsp_valid), 64'h0);
      chk($sformatf("t6_no_err_%0d", c), 64'(err_orphan), 64'h0);
      tick();
    end
    req_valid = 4'b1111;
    #1;
    chk("t6_ptr_zero", 64'(req_ready), 64'h1);
    req_valid = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
